debug_dump_ctrl: RTL and testbench
==================================

# debug_dump_ctrl

UART-driven debug controller for the pipeline: decodes command bytes from `uart_rx` and gates the pipeline step enable. It serialises a parametrised set of 32-bit debug words into the TX character FIFO feeding `uart_tx`. It replaces the fixed two-block PC/instruction dump with any word count, a free-run mode, and stall-safe FIFO back-pressure. It sits between `uart_rx`, `fifo`/`uart_tx` and `Pipeline`, all in the `clk` domain.

## Interface
- `NUM_WORDS`, default 8: number of debug words dumped; range 1–64.
- `WORD_W`, default 32: debug word width; must be a multiple of 8.
- `SETTLE_CYC`, default 2: idle cycles between a step pulse and the start of a dump; range 0–15.
- `clk  in  1`: system clock. One clock only.
- `rst  in  1`: synchronous, active-high reset.
- `rx_data  in  8`: received byte, valid while `rx_data_rdy` is high.
- `rx_data_rdy  in  1`: byte strobe from `uart_rx`; a byte is accepted on a 0→1 edge only.
- `dbg_words  in  NUM_WORDS*WORD_W`: flattened debug words; word k is at bits `[k*WORD_W +: WORD_W]`; word 0 is the PC.
- `fifo_full  in  1`: TX FIFO full.
- `fifo_din  out  8`: byte to the TX FIFO.
- `fifo_wr_en  out  1`: TX FIFO push.
- `pipe_step  out  1`: pipeline clock enable; one-cycle pulse per step.
- `busy  out  1`: high in every state except IDLE.

## Operation
- States: IDLE, STEP, SETTLE, DUMP, RUN.
- **IDLE:** an accepted byte is decoded as a command.
  - 'S' (0x53): go to STEP.
  - 'D' (0x44): go to DUMP.
  - 'R' (0x52): go to RUN.
  - Any other byte: one 0x3F ('?') push; the push is dropped silently if `fifo_full`.
- **STEP:** `pipe_step`=1 for exactly one cycle, then SETTLE.
- **SETTLE:** count `SETTLE_CYC` cycles, then DUMP. With `SETTLE_CYC`=0, SETTLE lasts 0 cycles and STEP goes straight to DUMP.
- **DUMP:**
  - Byte index `idx` runs 0 … `NUM_WORDS*WORD_W/8`−1.
  - Order: word 0 first, least-significant byte first within each word.
  - `idx` advances only on a cycle where a push occurs; after the last byte, go to IDLE.
  - `pipe_step` is never asserted in DUMP, so `dbg_words` is stable and sampled live; there is no shadow copy.
- **RUN:** `pipe_step`=1 every cycle. An accepted 'H' (0x48) drops `pipe_step` in the same cycle and goes to DUMP. Other bytes are ignored.
- Bytes accepted in STEP, SETTLE or DUMP are discarded with no echo.
- `idx` width is `$clog2(total bytes)`; no wrap beyond the final byte.

## Timing
- Reset values: state=IDLE, `fifo_wr_en`=0, `fifo_din`=0x00, `pipe_step`=0, `busy`=0, `idx`=0, settle counter=0, rx edge register=0.
- The state and all counters are registered.
- `fifo_wr_en` is combinational from the registered state and the live `fifo_full`: in DUMP, `fifo_wr_en` = !`fifo_full`.
- `fifo_din` is a combinational mux driven by `idx`.
- Command edge at cycle t:
  - 'D': first push at t+1.
  - 'S': `pipe_step` at t+1, first push at t+2+`SETTLE_CYC`.
- With no back-pressure, DUMP lasts exactly `NUM_WORDS*WORD_W/8` cycles, one byte per cycle.
- `fifo_full` high: no push and `idx` held. The dump resumes in the first cycle `fifo_full` is low, with no byte lost or duplicated.
- If 'H' arrives in the same cycle as a `fifo_full` change, 'H' takes priority.
- `rst` during any state:
  - Next cycle is IDLE, the partial dump is abandoned, and `pipe_step` is 0.
  - Bytes already in the FIFO are not touched.
- `rx_data_rdy` held high for multiple cycles counts as one byte.

## Configuration
- `DBG_DUMP_HEADER_EN` defined: each dump is framed as 0xA5, then the data bytes, then the XOR of all data bytes. Frame length is total bytes + 2. Header and checksum obey the same `fifo_full` stall rule.
- Undefined: raw data bytes only; no checksum logic is synthesised.

## Structure
- Package `dbg_pkg`:
  - Command constants `CMD_STEP`, `CMD_DUMP`, `CMD_RUN`, `CMD_HALT`.
  - `NAK_BYTE`=0x3F and `HDR_BYTE`=0xA5.
  - State enum `dbg_state_t`.
- One sub-module, `byte_serializer`: `idx`/advance logic plus word/byte mux and optional checksum accumulator, with a start/done handshake to the FSM.

## Test plan
- Setup for the first four scenarios: `NUM_WORDS`=2, words 0x11223344 and 0xAABBCCDD, FIFO never full.
  - 'D' → pushes 44 33 22 11 DD CC BB AA on 8 consecutive cycles; `pipe_step` never high.
  - 'D' with `DBG_DUMP_HEADER_EN` → pushes A5 44 33 22 11 DD CC BB AA 44.
  - 'S' with `SETTLE_CYC`=2 → `pipe_step` high for exactly 1 cycle; first push 3 cycles after the pulse.
  - 'R', wait 10 cycles, then 'H' → `pipe_step` high for 10+ consecutive cycles, low from the 'H' edge cycle, then a full 8-byte dump.
- `fifo_full` forced high for 5 cycles after the 3rd byte → exactly 8 bytes pushed, in order, with no duplicates.
- 'X' (0x58) in IDLE → a single 0x3F push. `rst` pulsed mid-dump after byte 4 → all outputs 0 the next cycle; a following 'D' restarts at byte 0x44.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants, state encoding and helpers for the UART debug dump controller.
package dbg_pkg;

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] NAK_BYTE = 8'h3F;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_DUMP,
        ST_RUN
    } dbg_state_t;

    // Counter width for n positions, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_STEP) || (b == CMD_DUMP) || (b == CMD_RUN);
    endfunction

endpackage

// File: rtl/debug_dump_ctrl_if.sv
// UART/FIFO/pipeline signal bundle of the debug dump controller.
interface debug_dump_ctrl_if #(
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned WORD_W    = 32
);
    logic [7:0]                  rx_data;
    logic                        rx_data_rdy;
    logic [NUM_WORDS*WORD_W-1:0] dbg_words;
    logic                        fifo_full;
    logic [7:0]                  fifo_din;
    logic                        fifo_wr_en;
    logic                        pipe_step;
    logic                        busy;

    modport master (
        input  rx_data, rx_data_rdy, dbg_words, fifo_full,
        output fifo_din, fifo_wr_en, pipe_step, busy
    );

    modport slave (
        output rx_data, rx_data_rdy, dbg_words, fifo_full,
        input  fifo_din, fifo_wr_en, pipe_step, busy
    );
endinterface

// File: rtl/byte_serializer.sv
// Walks the dump frame one byte per push; with DBG_DUMP_HEADER_EN the frame is
// wrapped in a 0xA5 header and an XOR checksum trailer.
module byte_serializer
    import dbg_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        push,
    input  logic [NUM_WORDS*WORD_W-1:0] words,
    output logic [7:0]                  byte_c,
    output logic                        done_c
);
    localparam int unsigned TOTAL = NUM_WORDS * WORD_W / 8;
`ifdef DBG_DUMP_HEADER_EN
    localparam int unsigned FRAME = TOTAL + 2;
`else
    localparam int unsigned FRAME = TOTAL;
`endif
    localparam int unsigned IDX_W  = idx_width(FRAME);
    localparam int unsigned DATA_W = idx_width(TOTAL);

    logic [IDX_W-1:0] idx;
    logic             last;
    logic [7:0]       bytes [TOTAL];

    // Words are packed LSB-first, so byte k of the flat vector is data byte k.
    for (genvar k = 0; k < int'(TOTAL); k++) begin : g_bytes
        assign bytes[k] = words[k*8 +: 8];
    end

    assign last   = (idx == IDX_W'(FRAME - 1));
    assign done_c = push && last;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            idx <= '0;
        end else if (push) begin
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

`ifdef DBG_DUMP_HEADER_EN
    logic [DATA_W-1:0] data_idx;
    logic [7:0]        data_byte;
    logic [7:0]        csum;

    assign data_idx  = DATA_W'(idx - IDX_W'(1));
    assign data_byte = bytes[data_idx];

    // Only data positions feed the checksum, header and trailer do not.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            csum <= '0;
        end else if (push && (idx != '0) && !last) begin
            csum <= csum ^ data_byte;
        end
    end

    always_comb begin
        byte_c = data_byte;
        if (idx == '0) begin
            byte_c = HDR_BYTE;
        end else if (last) begin
            byte_c = csum;
        end
    end
`else
    assign byte_c = bytes[DATA_W'(idx)];
`endif

endmodule

// File: rtl/debug_dump_ctrl.sv
// UART command decoder, pipeline step gate and debug-word dumper into the TX FIFO.
// Optional framing (header + XOR checksum) is enabled by DBG_DUMP_HEADER_EN.
module debug_dump_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 8,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    debug_dump_ctrl_if.master dbg
);
    dbg_state_t          state;
    dbg_state_t          state_nxt;
    logic                rx_q;
    logic                accept;
    logic                halt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                push;
    logic                start;
    logic                done;
    logic [7:0]          ser_byte;

    assign accept = dbg.rx_data_rdy && !rx_q;
    assign halt   = accept && (dbg.rx_data == CMD_HALT);
    assign start  = (state != ST_DUMP) && (state_nxt == ST_DUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte strobe edge detect and settle delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            rx_q       <= dbg.rx_data_rdy;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (dbg.rx_data)
                        CMD_STEP: state_nxt = ST_STEP;
                        CMD_DUMP: state_nxt = ST_DUMP;
                        CMD_RUN:  state_nxt = ST_RUN;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_STEP:   state_nxt = (SETTLE_CYC == 0) ? ST_DUMP : ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_DUMP;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push           = 1'b0;
        dbg.fifo_wr_en = 1'b0;
        dbg.fifo_din   = 8'h00;
        dbg.pipe_step  = 1'b0;
        dbg.busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept && !is_cmd(dbg.rx_data)) begin
                    dbg.fifo_wr_en = !dbg.fifo_full;
                    dbg.fifo_din   = NAK_BYTE;
                end
            end
            ST_STEP: dbg.pipe_step = 1'b1;
            ST_DUMP: begin
                push           = !dbg.fifo_full;
                dbg.fifo_wr_en = push;
                dbg.fifo_din   = ser_byte;
            end
            // A halt byte drops the step enable in the cycle it arrives.
            ST_RUN:  dbg.pipe_step = !halt;
            default: ;
        endcase
    end

    byte_serializer #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .push   (push),
        .words  (dbg.dbg_words),
        .byte_c (ser_byte),
        .done_c (done)
    );

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Randomized self-checking bench for debug_dump_ctrl against a frame-level reference model.
module tb_debug_dump_ctrl;
    localparam int unsigned NW    = 2;
    localparam int unsigned WW    = 32;
    localparam int unsigned SC    = 2;
    localparam int unsigned TOTAL = NW * WW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_dump_ctrl_if #(.NUM_WORDS(NW), .WORD_W(WW)) dbg();

    debug_dump_ctrl #(
        .NUM_WORDS  (NW),
        .WORD_W     (WW),
        .SETTLE_CYC (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dbg)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int          cyc     = 0;
    int          viol    = 0;
    int          stall_mode = 0;
    int          held    = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          push_cyc[$];
    int          pipe_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every FIFO push and every step pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (dbg.fifo_wr_en) begin
                got_q.push_back(dbg.fifo_din);
                push_cyc.push_back(cyc);
                if (dbg.fifo_full) viol++;
            end
            if (dbg.pipe_step) pipe_cyc.push_back(cyc);
        end
    end

    // FIFO back-pressure: 0 none, 1 random, 2 five cycles after 3rd byte, 3 always full.
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            1: dbg.fifo_full = ($urandom_range(0, 2) == 0);
            2: begin
                if (got_q.size() >= 3 && held < 5) begin
                    dbg.fifo_full = 1'b1;
                    held++;
                end else begin
                    dbg.fifo_full = 1'b0;
                end
            end
            3: dbg.fifo_full = 1'b1;
            default: dbg.fifo_full = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected dump frame built from the words as currently presented.
    task automatic build_exp();
        logic [7:0] x;
        logic [7:0] v;
        logic [NW*WW-1:0] w;
        w = dbg.dbg_words;
        x = 8'h00;
        exp_q.delete();
`ifdef DBG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int k = 0; k < int'(NW); k++) begin
            for (int b = 0; b < int'(WW / 8); b++) begin
                v = w[k*WW + b*8 +: 8];
                exp_q.push_back(v);
                x = x ^ v;
            end
        end
`ifdef DBG_DUMP_HEADER_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic clear();
        got_q.delete();
        push_cyc.delete();
        pipe_cyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold, output int ecyc);
        @(posedge clk);
        #1;
        dbg.rx_data     = b;
        dbg.rx_data_rdy = 1'b1;
        ecyc            = cyc;
        repeat (hold) @(posedge clk);
        #1;
        dbg.rx_data_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg.busy && n < 300);
        chk({tag, "_idle"}, 32'(dbg.busy), 32'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    function automatic int first_push();
        return (push_cyc.size() > 0) ? push_cyc[0] : -1000;
    endfunction

    initial begin
        int e, er, eh, gap, n;
        logic [7:0] b;
        rst             = 1'b1;
        dbg.rx_data     = 8'h00;
        dbg.rx_data_rdy = 1'b0;
        dbg.fifo_full   = 1'b0;
        dbg.dbg_words   = {32'hAABBCCDD, 32'h11223344};
        tick(3);
        @(negedge clk);
        chk("rst_wr_en", 32'(dbg.fifo_wr_en), 0);
        chk("rst_din",   32'(dbg.fifo_din),   0);
        chk("rst_pipe",  32'(dbg.pipe_step),  0);
        chk("rst_busy",  32'(dbg.busy),       0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);

        // Plain dump
        build_exp();
        clear();
        send(8'h44, 1, e);
        wait_idle("dump");
        check_frame("dump");
        chk("dump_pipe_cnt", pipe_cyc.size(), 0);
        chk("dump_first_lat", 32'(first_push() - e), 1);
        if (push_cyc.size() > 0)
            chk("dump_span", 32'(push_cyc[push_cyc.size()-1] - push_cyc[0]), exp_q.size() - 1);

        // Single step then dump
        clear();
        send(8'h53, 1, e);
        wait_idle("step");
        chk("step_pulses", pipe_cyc.size(), 1);
        if (pipe_cyc.size() > 0) begin
            chk("step_pulse_lat", 32'(pipe_cyc[0] - e), 1);
            chk("step_push_lat", 32'(first_push() - pipe_cyc[0]), SC + 1);
        end
        check_frame("step");

        // Free run then halt
        clear();
        send(8'h52, 1, er);
        tick(10);
        send(8'h48, 1, eh);
        wait_idle("run");
        chk("run_pulses", pipe_cyc.size(), 32'(eh - er - 1));
        if (pipe_cyc.size() > 0)
            chk("run_last_pulse", 32'(pipe_cyc[pipe_cyc.size()-1]), 32'(eh - 1));
        chk("run_dump_lat", 32'(first_push() - eh), 1);
        check_frame("run");

        // Five-cycle stall after the third byte
        clear();
        held = 0;
        stall_mode = 2;
        send(8'h44, 1, e);
        wait_idle("stall");
        stall_mode = 0;
        check_frame("stall");
        if (push_cyc.size() > 3)
            chk("stall_gap", 32'(push_cyc[3] - push_cyc[2]), 6);

        // Unknown byte, held high for several cycles
        clear();
        send(8'h58, 3, e);
        tick(3);
        chk("nak_cnt", got_q.size(), 1);
        if (got_q.size() > 0) chk("nak_byte", got_q[0], 8'h3F);
        chk("nak_lat", 32'(first_push() - e), 0);
        chk("nak_busy", 32'(dbg.busy), 0);

        // Unknown byte while FIFO full is dropped
        clear();
        stall_mode = 3;
        send(8'h5A, 1, e);
        tick(3);
        stall_mode = 0;
        tick(1);
        chk("nak_full_cnt", got_q.size(), 0);

        // Reset in the middle of a dump
        clear();
        send(8'h44, 1, e);
        n = 0;
        while (got_q.size() < 4 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rstmid_bytes", got_q.size(), 4);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_wr_en", 32'(dbg.fifo_wr_en), 0);
        chk("rstmid_din",   32'(dbg.fifo_din),   0);
        chk("rstmid_pipe",  32'(dbg.pipe_step),  0);
        chk("rstmid_busy",  32'(dbg.busy),       0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        clear();
        send(8'h44, 1, e);
        wait_idle("rerun");
        check_frame("rerun");

        // Randomized commands, words and back-pressure
        for (int it = 0; it < 40; it++) begin
            int cmd;
            int hold;
            dbg.dbg_words = {$urandom, $urandom};
            build_exp();
            clear();
            cmd  = $urandom_range(0, 3);
            hold = $urandom_range(1, 3);
            stall_mode = (cmd == 3) ? 0 : $urandom_range(0, 1);
            case (cmd)
                0, 1: begin
                    send((cmd == 0) ? 8'h44 : 8'h53, hold, e);
                    if ($urandom_range(0, 1) == 1) send(8'($urandom), 1, gap);
                    wait_idle("rnd_dump");
                    chk("rnd_pipe", pipe_cyc.size(), (cmd == 1) ? 1 : 0);
                    check_frame($sformatf("rnd%0d", it));
                end
                2: begin
                    send(8'h52, hold, er);
                    tick($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) send(8'h44, 1, gap);
                    send(8'h48, 1, eh);
                    wait_idle("rnd_run");
                    chk("rnd_run_pulses", pipe_cyc.size(), 32'(eh - er - 1));
                    check_frame($sformatf("rnd%0d", it));
                end
                default: begin
                    do b = 8'($urandom); while (b == 8'h53 || b == 8'h44 || b == 8'h52);
                    send(b, hold, e);
                    tick(3);
                    chk("rnd_nak_cnt", got_q.size(), 1);
                    if (got_q.size() > 0) chk("rnd_nak_byte", got_q[0], 8'h3F);
                end
            endcase
            stall_mode = 0;
            tick(2);
        end

        chk("no_push_while_full", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
